// File: rtl/tt_um_reg_alu.sv
// tt_um_reg_alu: a 4 x 8-bit register file with an 8-bit ALU and C/Z/N flags.
// One command from uio_in executes on each enabled rising edge.
// uo_out shows R[rd] combinationally.
// Optional build macro ALU_SAT_EN: ADD/ADC/INC clamp to 0xFF on carry, and
// SUB/DEC clamp to 0x00 on borrow. C still reports the unclamped carry or borrow.
module tt_um_reg_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_NOT = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_ADC = 4'hB,
    OP_INC = 4'hC, OP_DEC = 4'hD, OP_CMP = 4'hE, OP_RDF = 4'hF
  } op_e;

  logic [3:0][7:0] regs_q, regs_d;
  logic            c_q, z_q, n_q;
  logic            c_d, z_d, n_d;

  op_e        op;
  logic [1:0] rd, rs;
  logic [7:0] a, b, res;
  logic [8:0] sum9, dif9;
  logic       cout, wr, upd_c, upd_zn;

  assign op      = op_e'(uio_in[7:4]);
  assign rd      = uio_in[3:2];
  assign rs      = uio_in[1:0];
  assign a       = regs_q[rd];
  assign b       = regs_q[rs];
  assign uo_out  = regs_q[rd];
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Decode, compute the ALU result and the next register and flag values.
  always_comb begin
    res    = 8'h00;
    cout   = c_q;
    wr     = 1'b0;
    upd_c  = 1'b0;
    upd_zn = 1'b0;
    sum9   = 9'h000;
    dif9   = 9'h000;
    case (op)
      OP_LDI: begin res = ui_in; wr = 1'b1; end
      OP_MOV: begin res = b;     wr = 1'b1; end
      OP_ADD, OP_ADC, OP_INC: begin
        if (op == OP_INC) sum9 = {1'b0, b} + 9'd1;
        else              sum9 = {1'b0, a} + {1'b0, b} + {8'b0, (op == OP_ADC) & c_q};
        res  = sum9[7:0];
        cout = sum9[8];
`ifdef ALU_SAT_EN
        if (cout) res = 8'hFF;
`endif
        wr = 1'b1; upd_c = 1'b1; upd_zn = 1'b1;
      end
      OP_SUB, OP_DEC: begin
        if (op == OP_DEC) dif9 = {1'b0, b} - 9'd1;
        else              dif9 = {1'b0, a} - {1'b0, b};
        res  = dif9[7:0];
        cout = dif9[8];
`ifdef ALU_SAT_EN
        if (cout) res = 8'h00;
`endif
        wr = 1'b1; upd_c = 1'b1; upd_zn = 1'b1;
      end
      // Compare never writes a register, so its result is left unclamped.
      OP_CMP: begin
        dif9 = {1'b0, a} - {1'b0, b};
        res  = dif9[7:0];
        cout = dif9[8];
        upd_c = 1'b1; upd_zn = 1'b1;
      end
      OP_AND: begin res = a & b; wr = 1'b1; upd_zn = 1'b1; end
      OP_OR:  begin res = a | b; wr = 1'b1; upd_zn = 1'b1; end
      OP_XOR: begin res = a ^ b; wr = 1'b1; upd_zn = 1'b1; end
      OP_NOT: begin res = ~b;    wr = 1'b1; upd_zn = 1'b1; end
      OP_SHL: begin
        res = {b[6:0], 1'b0}; cout = b[7];
        wr = 1'b1; upd_c = 1'b1; upd_zn = 1'b1;
      end
      OP_SHR: begin
        res = {1'b0, b[7:1]}; cout = b[0];
        wr = 1'b1; upd_c = 1'b1; upd_zn = 1'b1;
      end
      OP_RDF: begin res = {5'b0, n_q, z_q, c_q}; wr = 1'b1; end
      default: ;
    endcase

    regs_d = regs_q;
    c_d    = c_q;
    z_d    = z_q;
    n_d    = n_q;
    if (ena) begin
      if (wr)     regs_d[rd] = res;
      if (upd_c)  c_d = cout;
      if (upd_zn) begin
        z_d = (res == 8'h00);
        n_d = res[7];
      end
    end
  end

  // Register file and flags, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      regs_q <= regs_d;
      c_q    <= c_d;
      z_q    <= z_d;
      n_q    <= n_d;
    end
  end

endmodule

// File: tb/tb_tt_um_reg_alu.sv
// Directed test bench for tt_um_reg_alu, default (wrap-around) build.
module tb_tt_um_reg_alu;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int n_chk = 0, n_fail = 0;

  tt_um_reg_alu dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h want 0x%02h", tag, obs, exp);
    end
  endtask

  // Apply a command and let it execute on the next edge; sample 1 time unit later.
  task automatic exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [7:0] imm);
    uio_in = {op, rd, rs};
    ui_in  = imm;
    @(posedge clk);
    #1;
  endtask

  // Select a register for display with a NOP command (no edge consumed).
  task automatic show(input logic [1:0] rd);
    uio_in = {4'h0, rd, 2'b00};
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    for (int r = 0; r < 4; r++) begin
      show(2'(r));
      chk($sformatf("rst_r%0d", r), uo_out, 8'h00);
    end
    chk("uio_oe", uio_oe, 8'h00);
    chk("uio_out", uio_out, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;

    exec(4'h1, 2'd0, 2'd0, 8'hA5); chk("ldi_r0", uo_out, 8'hA5);

    // add / carry
    exec(4'h1, 2'd1, 2'd0, 8'hF0);
    exec(4'h1, 2'd2, 2'd0, 8'h20);
    exec(4'h3, 2'd1, 2'd2, 8'h00); chk("add_r1", uo_out, 8'h10);
    exec(4'hF, 2'd3, 2'd0, 8'h00); chk("rdf_add", uo_out, 8'h01);
    exec(4'hB, 2'd1, 2'd2, 8'h00); chk("adc_r1", uo_out, 8'h31);
    exec(4'h3, 2'd1, 2'd1, 8'h00); chk("add_self", uo_out, 8'h62);

    // sub / compare
    exec(4'h1, 2'd0, 2'd0, 8'h05);
    exec(4'h1, 2'd1, 2'd0, 8'h05);
    exec(4'hE, 2'd0, 2'd1, 8'h00); chk("cmp_r0", uo_out, 8'h05);
    exec(4'hF, 2'd3, 2'd0, 8'h00); chk("rdf_cmp", uo_out, 8'h02);
    exec(4'h1, 2'd1, 2'd0, 8'h06);
    exec(4'h4, 2'd0, 2'd1, 8'h00); chk("sub_r0", uo_out, 8'hFF);
    exec(4'hF, 2'd3, 2'd0, 8'h00); chk("rdf_sub", uo_out, 8'h05);

    // logic / shift
    exec(4'h1, 2'd2, 2'd0, 8'h81);
    exec(4'h9, 2'd3, 2'd2, 8'h00); chk("shl_r3", uo_out, 8'h02);
    exec(4'hF, 2'd0, 2'd0, 8'h00); chk("rdf_shl", uo_out, 8'h01);
    exec(4'hA, 2'd3, 2'd2, 8'h00); chk("shr_r3", uo_out, 8'h40);
    exec(4'h7, 2'd2, 2'd2, 8'h00); chk("xor_r2", uo_out, 8'h00);
    exec(4'hF, 2'd0, 2'd0, 8'h00); chk("rdf_xor", uo_out, 8'h03);

    // inc / dec boundaries, not, and/or
    exec(4'h1, 2'd1, 2'd0, 8'hFF);
    exec(4'hC, 2'd1, 2'd1, 8'h00); chk("inc_wrap", uo_out, 8'h00);
    exec(4'hF, 2'd3, 2'd0, 8'h00); chk("rdf_inc", uo_out, 8'h03);
    exec(4'hD, 2'd1, 2'd1, 8'h00); chk("dec_wrap", uo_out, 8'hFF);
    exec(4'hF, 2'd3, 2'd0, 8'h00); chk("rdf_dec", uo_out, 8'h05);
    exec(4'h8, 2'd2, 2'd1, 8'h00); chk("not_r2", uo_out, 8'h00);
    exec(4'h1, 2'd2, 2'd0, 8'h3C);
    exec(4'h5, 2'd2, 2'd1, 8'h00); chk("and_r2", uo_out, 8'h3C);
    exec(4'h1, 2'd3, 2'd0, 8'hC0);
    exec(4'h6, 2'd2, 2'd3, 8'h00); chk("or_r2", uo_out, 8'hFC);
    exec(4'h2, 2'd0, 2'd2, 8'h00); chk("mov_r0", uo_out, 8'hFC);

    // enable gating
    ena = 1'b0;
    for (int i = 0; i < 3; i++) exec(4'h1, 2'd0, 2'd0, 8'h77);
    chk("ena_hold", uo_out, 8'hFC);
    ena = 1'b1;
    exec(4'h1, 2'd0, 2'd0, 8'h77); chk("ena_go", uo_out, 8'h77);

    // asynchronous reset between edges
    exec(4'h1, 2'd1, 2'd0, 8'h10); chk("pre_rst", uo_out, 8'h10);
    uio_in = 8'h04;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", uo_out, 8'h00);
    #2;
    rst_n = 1'b1;
    exec(4'h1, 2'd2, 2'd0, 8'h3C); chk("post_rst", uo_out, 8'h3C);
    exec(4'hF, 2'd3, 2'd0, 8'h00); chk("rdf_rst", uo_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
